// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: feeder state encoding and default burst geometry,
// common to the weight feeder and the array controller.
package sa_pkg;

   localparam int SA_DATA_W      = 8;
   localparam int SA_NUM_W       = 32;
   localparam int SA_ADDR_W      = 10;
   localparam int SA_COMPUTE_CYC = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      STREAM,
      COMPUTE,
      DONE
   } feeder_state_t;

endpackage

// File: rtl/sa_rd_pipe.sv
// Read-latency aligner: turns the weight-buffer read strobe and its one-cycle-late data
// into the registered w_ps/w_data timing seen by the array.
module sa_rd_pipe
   import sa_pkg::*;
#(
   parameter int DATA_W = SA_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              vld_p1,
   output logic              vld_p2,
   output logic [DATA_W-1:0] data_p2
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         data_p2 <= '0;
      end else if (clr) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
      end else begin
         // p1: read issued last cycle, data arriving on rd_data now
         vld_p1 <= rd_en;
         // p2: data captured; holds its last word once the burst ends
         vld_p2 <= vld_p1;
         if (vld_p1)
            data_p2 <= rd_data;
      end
   end

endmodule

// File: rtl/sa_weight_feeder.sv
// Weight feeder: fetches a burst of weights from the weight buffer, streams it into the
// array with w_ps high, then holds w_ps low for the compute phase and pulses done.
module sa_weight_feeder
   import sa_pkg::*;
#(
   parameter int DATA_W      = SA_DATA_W,
   parameter int NUM_W       = SA_NUM_W,
   parameter int ADDR_W      = SA_ADDR_W,
   parameter int COMPUTE_CYC = SA_COMPUTE_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              w_ps,
   output logic [DATA_W-1:0] w_data,
   output logic              busy,
   output logic              done
);

   localparam int RC_W = $clog2(NUM_W + 1);
   localparam int CC_W = $clog2(COMPUTE_CYC + 1);
   localparam logic [RC_W-1:0] NUM_W_C  = RC_W'(NUM_W);
   localparam logic [RC_W-1:0] NUM_W_M1 = RC_W'(NUM_W - 1);
   localparam logic [CC_W-1:0] CMP_M1   = CC_W'(COMPUTE_CYC - 1);

   feeder_state_t   state, state_nxt;
   logic [RC_W-1:0] rd_cnt, strm_cnt;
   logic [CC_W-1:0] cmp_cnt;
   logic            accept, abort_act, pipe_vld_p1;
   logic            busy_nxt, done_nxt;

   assign accept    = (state == IDLE) && start && !abort;
   assign abort_act = (state != IDLE) && abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort_act) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            // w_ps rises together with the move into STREAM
            FETCH:   if (pipe_vld_p1) state_nxt = STREAM;
            STREAM:  if (strm_cnt == NUM_W_M1) state_nxt = COMPUTE;
            COMPUTE: if (cmp_cnt == CMP_M1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy_nxt = (state_nxt == FETCH) || (state_nxt == STREAM) || (state_nxt == COMPUTE);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // Phase counters restart whenever their state is left, including on abort.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strm_cnt <= '0;
         cmp_cnt  <= '0;
      end else begin
         strm_cnt <= (state == STREAM  && state_nxt == STREAM)  ? strm_cnt + 1'b1 : '0;
         cmp_cnt  <= (state == COMPUTE && state_nxt == COMPUTE) ? cmp_cnt + 1'b1  : '0;
      end
   end

   // Read issue: NUM_W back-to-back reads starting the cycle after accept, address wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         rd_cnt    <= '0;
      end else if (accept) begin
         mem_rd_en <= 1'b1;
         mem_addr  <= base_addr;
         rd_cnt    <= RC_W'(1);
      end else if (abort_act || state == IDLE) begin
         mem_rd_en <= 1'b0;
         rd_cnt    <= '0;
      end else if (mem_rd_en && rd_cnt != NUM_W_C) begin
         mem_addr  <= mem_addr + 1'b1;
         rd_cnt    <= rd_cnt + 1'b1;
      end else begin
         mem_rd_en <= 1'b0;
      end
   end

   sa_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .clr     (abort_act),
      .rd_en   (mem_rd_en),
      .rd_data (mem_rd_data),
      .vld_p1  (pipe_vld_p1),
      .vld_p2  (w_ps),
      .data_p2 (w_data)
   );

endmodule

// File: tb/tb_sa_weight_feeder.sv
// Directed bench for sa_weight_feeder with a registered weight-buffer model.
module tb_sa_weight_feeder;
   import sa_pkg::*;

   localparam int DATA_W      = 8;
   localparam int NUM_W       = 32;
   localparam int ADDR_W      = 10;
   localparam int COMPUTE_CYC = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              w_ps;
   logic [DATA_W-1:0] w_data;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] mem [1024];

   int tests_run    = 0;
   int tests_failed = 0;

   sa_weight_feeder #(
      .DATA_W      (DATA_W),
      .NUM_W       (NUM_W),
      .ADDR_W      (ADDR_W),
      .COMPUTE_CYC (COMPUTE_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .abort       (abort),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .w_ps        (w_ps),
      .w_data      (w_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_rd_en)
         mem_rd_data <= mem[mem_addr];

   function automatic logic [7:0] mem_val(input logic [9:0] a);
      return 8'(a + 10'd1);
   endfunction

   // Expected {rd_en, addr, w_ps, w_data, busy, done} k cycles after the start cycle;
   // addr/w_data are zeroed where they are don't-care.
   function automatic logic [21:0] exp_vec(input int k, input logic [9:0] base);
      logic       rd, wp, bz, dn;
      logic [9:0] ad;
      logic [7:0] wd;
      rd = (k >= 1) && (k <= 32);
      ad = rd ? base + 10'(k - 1) : 10'd0;
      wp = (k >= 3) && (k <= 34);
      wd = wp ? mem_val(base + 10'(k - 3)) : 8'd0;
      bz = (k >= 1) && (k <= 66);
      dn = (k == 67);
      return {rd, ad, wp, wd, bz, dn};
   endfunction

   function automatic logic [21:0] act_vec();
      return {mem_rd_en, mem_rd_en ? mem_addr : 10'd0, w_ps, w_ps ? w_data : 8'd0, busy, done};
   endfunction

   task automatic test_reset();
      #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (act_vec() !== 22'd0 || mem_addr !== 10'd0 || w_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_hold k=%0d got %h addr=%h wdata=%h exp all zero",
                     k, act_vec(), mem_addr, w_data);
         end
      end
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         tests_run++;
         if (act_vec() !== 22'd0 || mem_addr !== 10'd0 || w_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_idle k=%0d got %h addr=%h wdata=%h exp all zero",
                     k, act_vec(), mem_addr, w_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_nominal();
      int nwps = 0, ndone = 0;
      base_addr = 10'd0;
      start = 1'b1;
      for (int k = 0; k < 70; k++) begin
         if (k == 1) start = 1'b0;
         @(negedge clk);
         tests_run++;
         if (act_vec() !== exp_vec(k, 10'd0)) begin
            tests_failed++;
            $display("FAIL nominal k=%0d got %h exp %h", k, act_vec(), exp_vec(k, 10'd0));
         end
         nwps += int'(w_ps);
         ndone += int'(done);
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (nwps !== 32 || ndone !== 1) begin
         tests_failed++;
         $display("FAIL nominal_counts wps=%0d done=%0d exp 32 1", nwps, ndone);
      end
   endtask

   task automatic test_wrap();
      base_addr = 10'd1020;
      start = 1'b1;
      for (int k = 0; k < 70; k++) begin
         if (k == 1) start = 1'b0;
         @(negedge clk);
         tests_run++;
         if (act_vec() !== exp_vec(k, 10'd1020)) begin
            tests_failed++;
            $display("FAIL wrap k=%0d got %h exp %h", k, act_vec(), exp_vec(k, 10'd1020));
         end
         if (k == 5) begin
            tests_run++;
            if (mem_addr !== 10'd0) begin
               tests_failed++;
               $display("FAIL wrap_addr0 got %0d exp 0", mem_addr);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_start_while_busy();
      int nwps = 0, ndone = 0;
      base_addr = 10'd0;
      for (int k = 0; k < 80; k++) begin
         start = (k == 0) || (k == 10) || (k == 67);
         @(negedge clk);
         tests_run++;
         if (act_vec() !== exp_vec(k, 10'd0)) begin
            tests_failed++;
            $display("FAIL start_busy k=%0d got %h exp %h", k, act_vec(), exp_vec(k, 10'd0));
         end
         nwps += int'(w_ps);
         ndone += int'(done);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      tests_run++;
      if (nwps !== 32 || ndone !== 1) begin
         tests_failed++;
         $display("FAIL start_busy_counts wps=%0d done=%0d exp 32 1", nwps, ndone);
      end
   endtask

   task automatic test_abort();
      int nwps = 0, ndone = 0;
      logic [21:0] e;
      base_addr = 10'd0;
      for (int k = 0; k < 90; k++) begin
         start = (k == 0) || (k == 20);
         abort = (k == 15);
         if (k == 20) base_addr = 10'd100;
         e = (k <= 15) ? exp_vec(k, 10'd0) : exp_vec(k - 20, 10'd100);
         @(negedge clk);
         tests_run++;
         if (act_vec() !== e) begin
            tests_failed++;
            $display("FAIL abort k=%0d got %h exp %h", k, act_vec(), e);
         end
         nwps += int'(w_ps);
         ndone += int'(done);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      abort = 1'b0;
      tests_run++;
      if (nwps !== 45 || ndone !== 1) begin
         tests_failed++;
         $display("FAIL abort_counts wps=%0d done=%0d exp 45 1", nwps, ndone);
      end
   endtask

   task automatic test_abort_idle();
      base_addr = 10'd5;
      start = 1'b1;
      abort = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 1) begin
            start = 1'b0;
            abort = 1'b0;
         end
         @(negedge clk);
         tests_run++;
         if (act_vec() !== 22'd0) begin
            tests_failed++;
            $display("FAIL abort_idle k=%0d got %h exp 0", k, act_vec());
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_async_reset();
      base_addr = 10'd0;
      start = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (k == 1) start = 1'b0;
         @(negedge clk);
         tests_run++;
         if (act_vec() !== exp_vec(k, 10'd0)) begin
            tests_failed++;
            $display("FAIL async_pre k=%0d got %h exp %h", k, act_vec(), exp_vec(k, 10'd0));
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (act_vec() !== exp_vec(50, 10'd0)) begin
         tests_failed++;
         $display("FAIL async_k50 got %h exp %h", act_vec(), exp_vec(50, 10'd0));
      end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (act_vec() !== 22'd0 || mem_addr !== 10'd0 || w_data !== 8'd0) begin
         tests_failed++;
         $display("FAIL async_clear got %h addr=%h wdata=%h exp all zero", act_vec(), mem_addr, w_data);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      base_addr = 10'd0;
      start = 1'b1;
      for (int k = 0; k < 70; k++) begin
         if (k == 1) start = 1'b0;
         @(negedge clk);
         tests_run++;
         if (act_vec() !== exp_vec(k, 10'd0)) begin
            tests_failed++;
            $display("FAIL async_post k=%0d got %h exp %h", k, act_vec(), exp_vec(k, 10'd0));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] = 8'(i + 1);
      test_reset();
      test_nominal();
      test_wrap();
      test_start_while_busy();
      test_abort();
      test_abort_idle();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
